// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// Multicycle main control state machine for the RV32I core. Walks each
// instruction through fetch, decode, execute, memory and writeback, and
// drives the datapath enables/muxes plus the ALU_Control handshake pair.

module mc_control_fsm (
   input  logic       clk,
   input  logic       rst_i,
   input  logic [6:0] opcode_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       pc_write_cond_o,
   output logic       pc_source_o,
   output logic       lord_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic       reg_write_o,
   output logic       mem_to_reg_o,
   output logic [1:0] alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [1:0] ALU_CO_o,
   output logic       is_immediate_o,
   output logic       illegal_o,
   output logic [3:0] state_o
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_JALR     = 4'd11;
   localparam logic [3:0] S_LUI      = 4'd12;
   localparam logic [3:0] S_AUIPC    = 4'd13;

   logic [3:0] r_state;
   logic       r_illegal;
   logic [3:0] w_next;
   logic       w_decodeIllegal;

   logic       w_pcWrite;
   logic       w_pcWriteCond;
   logic       w_irWrite;
   logic       w_regWrite;
   logic       w_memWrite;

   // Next-state selection; DECODE also flags opcodes we do not implement
   always_comb begin
      w_next          = S_FETCH;
      w_decodeIllegal = 1'b0;
      case (r_state)
         S_FETCH:    w_next = mem_ready_i ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode_i)
               7'b0000011,
               7'b0100011: w_next = S_MEMADR;
               7'b0110011: w_next = S_EXECR;
               7'b0010011: w_next = S_EXECI;
               7'b1100011: w_next = S_BRANCH;
               7'b1101111: w_next = S_JAL;
               7'b1100111: w_next = S_JALR;
               7'b0110111: w_next = S_LUI;
               7'b0010111: w_next = S_AUIPC;
               default: begin
                  w_next          = S_FETCH;
                  w_decodeIllegal = 1'b1;
               end
            endcase
         end
         S_MEMADR:   w_next = opcode_i[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  w_next = mem_ready_i ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWRITE: w_next = mem_ready_i ? S_FETCH : S_MEMWRITE;
         S_EXECR:    w_next = S_ALUWB;
         S_EXECI:    w_next = S_ALUWB;
         S_ALUWB:    w_next = S_FETCH;
         S_BRANCH:   w_next = S_FETCH;
         S_JAL:      w_next = S_ALUWB;
         S_JALR:     w_next = S_JAL;
         S_LUI:      w_next = S_ALUWB;
         S_AUIPC:    w_next = S_ALUWB;
         default:    w_next = S_FETCH;
      endcase
   end

   // State register and the sticky illegal-opcode flag
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_decodeIllegal) begin
            r_illegal <= 1'b1;
         end
      end
   end

   // Moore output decode; only FETCH looks at mem_ready_i so a wait loads nothing
   always_comb begin
      w_pcWrite       = 1'b0;
      w_pcWriteCond   = 1'b0;
      w_irWrite       = 1'b0;
      w_regWrite      = 1'b0;
      w_memWrite      = 1'b0;
      pc_source_o     = 1'b0;
      lord_o          = 1'b0;
      mem_read_o      = 1'b0;
      mem_to_reg_o    = 1'b0;
      alu_src_a_o     = 2'b00;
      alu_src_b_o     = 2'b00;
      ALU_CO_o        = 2'b00;
      is_immediate_o  = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = 2'b01;
            w_irWrite   = mem_ready_i;
            w_pcWrite   = mem_ready_i;
         end
         S_DECODE: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b10;
         end
         S_MEMADR: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b10;
         end
         S_MEMREAD: begin
            mem_read_o = 1'b1;
            lord_o     = 1'b1;
         end
         S_MEMWB: begin
            w_regWrite   = 1'b1;
            mem_to_reg_o = 1'b1;
         end
         S_MEMWRITE: begin
            w_memWrite = 1'b1;
            lord_o     = 1'b1;
         end
         S_EXECR: begin
            alu_src_a_o = 2'b10;
            ALU_CO_o    = 2'b10;
         end
         S_EXECI: begin
            alu_src_a_o    = 2'b10;
            alu_src_b_o    = 2'b10;
            ALU_CO_o       = 2'b10;
            is_immediate_o = 1'b1;
         end
         S_ALUWB: begin
            w_regWrite = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_o   = 2'b10;
            ALU_CO_o      = 2'b01;
            w_pcWriteCond = 1'b1;
            pc_source_o   = 1'b1;
         end
         S_JAL: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b01;
            w_pcWrite   = 1'b1;
            pc_source_o = 1'b1;
         end
         S_JALR: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b10;
         end
         S_LUI: begin
            alu_src_a_o = 2'b11;
            alu_src_b_o = 2'b10;
         end
         S_AUIPC: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b10;
         end
         default: begin
         end
      endcase
   end

   // Write enables are squashed for the whole time reset is held
   assign pc_write_o      = w_pcWrite     & ~rst_i;
   assign pc_write_cond_o = w_pcWriteCond & ~rst_i;
   assign ir_write_o      = w_irWrite     & ~rst_i;
   assign reg_write_o     = w_regWrite    & ~rst_i;
   assign mem_write_o     = w_memWrite    & ~rst_i;

   assign illegal_o = r_illegal;
   assign state_o   = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
// Scoreboard bench: each driven cycle pushes the expected output bundle,
// which is popped and compared once the DUT outputs have settled.

module tb_mc_control_fsm;

   typedef logic [20:0] vec_t;

   logic       clk = 1'b0;
   logic       rstI;
   logic [6:0] opcode;
   logic       memReady;
   logic       pcWrite, pcWriteCond, pcSource, lord, memRead, memWrite;
   logic       irWrite, regWrite, memToReg, isImm, illegal;
   logic [1:0] srcA, srcB, aluCo;
   logic [3:0] state;

   int   vecCount  = 0;
   int   missCount = 0;
   int   cycleNo   = 0;
   logic expIllegal = 1'b0;
   vec_t expQ[$];

   mc_control_fsm dut (
      .clk             (clk),
      .rst_i           (rstI),
      .opcode_i        (opcode),
      .mem_ready_i     (memReady),
      .pc_write_o      (pcWrite),
      .pc_write_cond_o (pcWriteCond),
      .pc_source_o     (pcSource),
      .lord_o          (lord),
      .mem_read_o      (memRead),
      .mem_write_o     (memWrite),
      .ir_write_o      (irWrite),
      .reg_write_o     (regWrite),
      .mem_to_reg_o    (memToReg),
      .alu_src_a_o     (srcA),
      .alu_src_b_o     (srcB),
      .ALU_CO_o        (aluCo),
      .is_immediate_o  (isImm),
      .illegal_o       (illegal),
      .state_o         (state)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Expected outputs for a state, taken from the control table
   function automatic vec_t expOut(input logic [3:0] st, input logic rdy,
                                   input logic ill, input logic inRst);
      logic pcW, pcWC, pcSrc, ld, mRd, mWr, irW, rW, m2r, imm;
      logic [1:0] a, b, co;
      {pcW, pcWC, pcSrc, ld, mRd, mWr, irW, rW, m2r, imm} = '0;
      a = 2'b00; b = 2'b00; co = 2'b00;
      case (st)
         4'd0:  begin mRd = 1'b1; b = 2'b01; irW = rdy; pcW = rdy; end
         4'd1:  begin a = 2'b01; b = 2'b10; end
         4'd2:  begin a = 2'b10; b = 2'b10; end
         4'd3:  begin mRd = 1'b1; ld = 1'b1; end
         4'd4:  begin rW = 1'b1; m2r = 1'b1; end
         4'd5:  begin mWr = 1'b1; ld = 1'b1; end
         4'd6:  begin a = 2'b10; co = 2'b10; end
         4'd7:  begin a = 2'b10; b = 2'b10; co = 2'b10; imm = 1'b1; end
         4'd8:  begin rW = 1'b1; end
         4'd9:  begin a = 2'b10; co = 2'b01; pcWC = 1'b1; pcSrc = 1'b1; end
         4'd10: begin a = 2'b01; b = 2'b01; pcW = 1'b1; pcSrc = 1'b1; end
         4'd11: begin a = 2'b10; b = 2'b10; end
         4'd12: begin a = 2'b11; b = 2'b10; end
         4'd13: begin a = 2'b01; b = 2'b10; end
         default: begin end
      endcase
      if (inRst) begin
         {pcW, pcWC, irW, rW, mWr} = '0;
      end
      return {pcW, pcWC, pcSrc, ld, mRd, mWr, irW, rW, m2r, a, b, co, imm, ill, st};
   endfunction

   // Single comparison point: counts the vector and reports any miscompare
   task automatic checkOutput(input string tag, input vec_t observed, input vec_t expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Pop the oldest expectation and compare it with the settled DUT outputs
   task automatic sampleOutputs(input string tag);
      vec_t obs;
      obs = {pcWrite, pcWriteCond, pcSource, lord, memRead, memWrite, irWrite,
             regWrite, memToReg, srcA, srcB, aluCo, isImm, illegal, state};
      if (expQ.size() == 0) begin
         checkOutput({tag, "_noexp"}, obs, ~obs);
      end else begin
         checkOutput(tag, obs, expQ.pop_front());
      end
   endtask

   // Drive one cycle of inputs at the falling edge and record what must come out
   task automatic applyStimulus(input logic [6:0] op, input logic rdy, input logic [3:0] expState);
      @(negedge clk);
      opcode   = op;
      memReady = rdy;
      cycleNo++;
      expQ.push_back(expOut(expState, rdy, expIllegal, rstI));
      #1;
      sampleOutputs($sformatf("c%0d_s%0d", cycleNo, expState));
   endtask

   // Run n cycles; state i is nibble i of states, ready i is bit i of rdyMask
   task automatic runInstr(input logic [6:0] op, input int n,
                           input logic [31:0] states, input logic [7:0] rdyMask);
      for (int i = 0; i < n; i++) begin
         applyStimulus(op, rdyMask[i], states[4*i +: 4]);
      end
   endtask

   initial begin
      rstI     = 1'b1;
      opcode   = 7'b0110011;
      memReady = 1'b1;

      // reset with ready high: FETCH decode, but no writes allowed
      applyStimulus(7'b0110011, 1'b1, 4'd0);
      applyStimulus(7'b0110011, 1'b1, 4'd0);

      // release with ready low so the next edge stays in FETCH
      @(negedge clk);
      memReady = 1'b0;
      rstI     = 1'b0;

      runInstr(7'b0110011, 4, 32'h8610,    8'hFF);       // R-type
      runInstr(7'b0000011, 7, 32'h4333210, 8'b11100111); // load, 2 waits
      runInstr(7'b1100011, 6, 32'h910000,  8'b11111000); // fetch wait, branch
      runInstr(7'b1100111, 5, 32'h8AB10,   8'hFF);       // JALR
      runInstr(7'b0100011, 5, 32'h55210,   8'b11110111); // store, 1 wait
      runInstr(7'b1101111, 4, 32'h8A10,    8'hFF);       // JAL
      runInstr(7'b0010011, 4, 32'h8710,    8'hFF);       // I-type
      runInstr(7'b0110111, 4, 32'h8C10,    8'hFF);       // LUI
      runInstr(7'b0010111, 4, 32'h8D10,    8'hFF);       // AUIPC
      runInstr(7'b1111111, 2, 32'h10,      8'hFF);       // unknown opcode
      expIllegal = 1'b1;
      runInstr(7'b1100011, 3, 32'h910,     8'hFF);       // keeps sequencing
      runInstr(7'b0000011, 3, 32'h210,     8'hFF);       // stop in MEMADR

      // asynchronous reset between clock edges while in MEMADR
      #2;
      rstI = 1'b1;
      expIllegal = 1'b0;
      #1;
      expQ.push_back(expOut(4'd0, memReady, 1'b0, 1'b1));
      sampleOutputs("async_rst");
      applyStimulus(7'b0000011, 1'b1, 4'd0);

      @(negedge clk);
      memReady = 1'b0;
      rstI     = 1'b0;
      runInstr(7'b0110011, 5, 32'h08610, 8'hFF);         // clean restart

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
